// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit accumulator ALU and its command issuer.
//   - ALU opcode map constants
//   - alu_cmd_t: one queued command (opcode + operand), 20 bits packed
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_RST  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NOT  = 4'b1101;

  localparam int CMD_W = 20;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [15:0] operand;
  } alu_cmd_t;

  // True for opcodes that count as real work in issue_count.
  function automatic logic is_work_op(input logic [3:0] op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command stream from the producer into the issuer.
//   in_valid   : producer has a command
//   in_opcode  : 4-bit ALU opcode
//   in_operand : 16-bit operand
//   in_ready   : issuer can accept
// Handshake: a command transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready does not depend on in_valid. The producer
// keeps in_valid/in_opcode/in_operand stable until the transfer happens.
interface alu_cmd_issuer_if;
  logic        in_valid;
  logic [3:0]  in_opcode;
  logic [15:0] in_operand;
  logic        in_ready;

  modport master (output in_valid, output in_opcode, output in_operand, input in_ready);
  modport slave  (input in_valid, input in_opcode, input in_operand, output in_ready);
endinterface

// File: rtl/alu_cmd_issuer_fifo.sv
// cmd_fifo: small synchronous FIFO of ALU commands.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata at the tail (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   wdata    : entry to write
//   rdata    : head entry, combinational
//   count    : occupancy 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// Occupancy is an explicit counter so full/empty never depend on pointer
// compare; the pointers simply wrap at DEPTH (a power of 2).
module cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] wdata,
  output logic [CMD_W-1:0] rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers producer commands and issues one per clock to the
// ALU, substituting NOP when the queue is empty or issue is halted by an
// ALU error.
//   clk, rst     : clock, asynchronous active-high reset
//   cmd_if       : producer command stream (slave side)
//   alu_opcode   : registered opcode to the ALU
//   alu_operand  : registered operand to the ALU A input
//   alu_err      : ALU error bit for the command currently presented
//   clear_err    : pulse that clears err_sticky
//   err_sticky   : issue halted since an ALU error
//   fifo_count   : queue occupancy
//   issue_count  : non-NOP commands issued, wraps at 16 bits
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  alu_cmd_issuer_if.slave    cmd_if,
  output logic [3:0]         alu_opcode,
  output logic [15:0]        alu_operand,
  input  logic               alu_err,
  input  logic               clear_err,
  output logic               err_sticky,
  output logic [PTR_W:0]     fifo_count,
  output logic [15:0]        issue_count
);

  alu_cmd_t       head;
  alu_cmd_t       wcmd;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           issue_en;

  logic [3:0]     alu_opcode_q, alu_opcode_d;
  logic [15:0]    alu_operand_q, alu_operand_d;
  logic           err_sticky_q, err_sticky_d;
  logic [15:0]    issue_count_q, issue_count_d;

  assign cmd_if.in_ready = !fifo_full;
  assign push            = cmd_if.in_valid && !fifo_full;
  assign wcmd            = '{opcode: cmd_if.in_opcode, operand: cmd_if.in_operand};

  // An error seen at this edge blocks the pop immediately, so the head that
  // would have followed the overflowing command stays queued.
  assign issue_en = !err_sticky_q && !alu_err && !fifo_empty;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (issue_en),
    .wdata (wcmd),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    alu_opcode_d  = OP_NOP;
    alu_operand_d = '0;
    issue_count_d = issue_count_q;
    err_sticky_d  = err_sticky_q;
    if (issue_en) begin
      alu_opcode_d  = head.opcode;
      alu_operand_d = head.operand;
      if (is_work_op(head.opcode)) begin
        issue_count_d = issue_count_q + 16'd1;
      end
    end
    // Error has priority over a simultaneous clear.
    if (alu_err) begin
      err_sticky_d = 1'b1;
    end else if (clear_err) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode_q  <= OP_NOP;
      alu_operand_q <= '0;
      err_sticky_q  <= 1'b0;
      issue_count_q <= '0;
    end else begin
      alu_opcode_q  <= alu_opcode_d;
      alu_operand_q <= alu_operand_d;
      err_sticky_q  <= err_sticky_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign alu_opcode  = alu_opcode_q;
  assign alu_operand = alu_operand_q;
  assign err_sticky  = err_sticky_q;
  assign issue_count = issue_count_q;

endmodule
